// File: rtl/rr_response_router_if.sv
// rr_response_router_if: grant, PLM data, response and statistics bundle
interface rr_response_router_if #(
    parameter int VALUE_WIDTH = 8,
    parameter int NCONSUMERS = 2,
    parameter int NBANKS = 2,
    parameter int NPORTS = 1,
    parameter int CNT_WIDTH = 16
);
    localparam int NKERNELS = NBANKS * NPORTS;
    localparam int CW = NCONSUMERS > 1 ? $clog2(NCONSUMERS) : 1;
    logic [NKERNELS-1:0] grant_valid;
    logic [NKERNELS-1:0][CW-1:0] grant_consumer;
    logic [NKERNELS-1:0] grant_wr;
    logic [NKERNELS-1:0][VALUE_WIDTH-1:0] plm_outputs;
    logic clear_stats;
    logic [NCONSUMERS-1:0] req_ack;
    logic [NCONSUMERS-1:0] resp_valid;
    logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data;
    logic [NCONSUMERS-1:0] resp_is_write;
    logic [NKERNELS-1:0][CNT_WIDTH-1:0] grant_count;
    logic [1:0] error;
    modport master (
        output grant_valid, grant_consumer, grant_wr, plm_outputs, clear_stats,
        input req_ack, resp_valid, resp_data, resp_is_write, grant_count, error
    );
    modport slave (
        input grant_valid, grant_consumer, grant_wr, plm_outputs, clear_stats,
        output req_ack, resp_valid, resp_data, resp_is_write, grant_count, error
    );
endinterface

// File: rtl/rr_response_router.sv
// rr_response_router: acknowledges kernel grants and routes PLM responses back to consumers
module rr_response_router #(
    parameter int VALUE_WIDTH = 8,
    parameter int NCONSUMERS = 2,
    parameter int NBANKS = 2,
    parameter int NPORTS = 1,
    parameter int PLM_LATENCY = 1,
    parameter int CNT_WIDTH = 16
) (
    input logic clk,
    input logic reset,
    rr_response_router_if.slave bus
);
    localparam int NK = NBANKS * NPORTS;
    localparam int CW = NCONSUMERS > 1 ? $clog2(NCONSUMERS) : 1;
    localparam int T = PLM_LATENCY - 1;
    logic [PLM_LATENCY-1:0][NK-1:0] pv;
    logic [PLM_LATENCY-1:0][NK-1:0][CW-1:0] pc;
    logic [PLM_LATENCY-1:0][NK-1:0] pw;
    logic [NK-1:0] oor;
    logic [NCONSUMERS-1:0] hit;
    logic [NCONSUMERS-1:0] hit_wr;
    logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] hit_data;
    logic coll;

    // acknowledge in the grant cycle and flag consumer indices that do not exist
    always_comb begin
        bus.req_ack = '0;
        oor = '0;
        for (int k = 0; k < NK; k++) begin
            oor[k] = bus.grant_valid[k] && (int'(bus.grant_consumer[k]) >= NCONSUMERS);
            for (int c = 0; c < NCONSUMERS; c++)
                if (bus.grant_valid[k] && bus.grant_consumer[k] == CW'(c)) bus.req_ack[c] = 1'b1;
        end
    end

    // pick the lowest-index tail kernel per consumer; any further claimant is a collision
    always_comb begin
        hit = '0;
        hit_wr = '0;
        hit_data = '0;
        coll = 1'b0;
        for (int c = 0; c < NCONSUMERS; c++)
            for (int k = 0; k < NK; k++)
                if (pv[T][k] && pc[T][k] == CW'(c)) begin
                    if (hit[c]) coll = 1'b1;
                    else begin
                        hit[c] = 1'b1;
                        hit_wr[c] = pw[T][k];
                        hit_data[c] = pw[T][k] ? '0 : bus.plm_outputs[k];
                    end
                end
    end

    // valid line: out-of-range grants never enter, reset discards in-flight grants
    always_ff @(posedge clk) begin
        if (reset) pv <= '0;
        else begin
            pv[0] <= bus.grant_valid & ~oor;
            for (int s = 1; s < PLM_LATENCY; s++) pv[s] <= pv[s-1];
        end
    end

    // payload line travels alongside the valids and needs no reset
    always_ff @(posedge clk) begin
        pc[0] <= bus.grant_consumer;
        pw[0] <= bus.grant_wr;
        for (int s = 1; s < PLM_LATENCY; s++) begin
            pc[s] <= pc[s-1];
            pw[s] <= pw[s-1];
        end
    end

    // response registers; data and write flag hold when the consumer gets nothing
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.resp_valid <= '0;
            bus.resp_data <= '0;
            bus.resp_is_write <= '0;
        end else begin
            bus.resp_valid <= hit;
            for (int c = 0; c < NCONSUMERS; c++)
                if (hit[c]) begin
                    bus.resp_data[c] <= hit_data[c];
                    bus.resp_is_write[c] <= hit_wr[c];
                end
        end
    end

    // sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        bus.error <= reset ? 2'b00 : bus.error | {|oor, coll};
    end

    // saturating per-kernel grant counters; clearing beats a coincident increment
    always_ff @(posedge clk) begin
        for (int k = 0; k < NK; k++)
            if (reset || bus.clear_stats) bus.grant_count[k] <= '0;
            else if (bus.grant_valid[k] && !(&bus.grant_count[k])) bus.grant_count[k] <= bus.grant_count[k] + 1'b1;
    end
endmodule

// File: tb/tb_rr_response_router.sv
// tb_rr_response_router: directed checks of acknowledge, routing, errors and counters
module tb_rr_response_router;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int passed = 0;
    int total = 0;

    rr_response_router_if #(.CNT_WIDTH(4)) a();
    rr_response_router_if #(.NCONSUMERS(3)) b();

    rr_response_router #(.PLM_LATENCY(1), .CNT_WIDTH(4)) u_a (.clk(clk), .reset(reset), .bus(a.slave));
    rr_response_router #(.NCONSUMERS(3), .PLM_LATENCY(2)) u_b (.clk(clk), .reset(reset), .bus(b.slave));

    // free-running clock
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a.grant_valid = '0; a.grant_consumer = '0; a.grant_wr = '0; a.plm_outputs = '0; a.clear_stats = 1'b0;
        b.grant_valid = '0; b.grant_consumer = '0; b.grant_wr = '0; b.plm_outputs = '0; b.clear_stats = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        reset = 1'b1;
        a.grant_valid = 2'b01; a.grant_consumer[0] = 1'b1;
        #1;
        total++; if (a.req_ack !== 2'b10) $display("FAIL reset_ack got %b want 10", a.req_ack); else passed++;
        tick(); tick();
        idle();
        total++; if (a.resp_valid !== 2'b00) $display("FAIL reset_rv_a got %b want 00", a.resp_valid); else passed++;
        total++; if (a.error !== 2'b00) $display("FAIL reset_err_a got %b want 00", a.error); else passed++;
        total++; if (a.grant_count !== '0) $display("FAIL reset_cnt_a got %h want 0", a.grant_count); else passed++;
        total++; if (b.resp_valid !== 3'b000 || b.resp_data !== '0) $display("FAIL reset_b got %b/%h want 0/0", b.resp_valid, b.resp_data); else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read;
        a.grant_valid = 2'b01; a.grant_consumer[0] = 1'b1; a.grant_wr = 2'b00;
        #1;
        total++; if (a.req_ack !== 2'b10) $display("FAIL read_ack got %b want 10", a.req_ack); else passed++;
        tick();
        idle(); a.plm_outputs[0] = 8'hA5;
        total++; if (a.resp_valid !== 2'b00) $display("FAIL read_early got %b want 00", a.resp_valid); else passed++;
        tick();
        idle();
        total++; if (a.resp_valid !== 2'b10) $display("FAIL read_rv got %b want 10", a.resp_valid); else passed++;
        total++; if (a.resp_data[1] !== 8'hA5) $display("FAIL read_data got %h want a5", a.resp_data[1]); else passed++;
        total++; if (a.resp_is_write[1] !== 1'b0) $display("FAIL read_wr got %b want 0", a.resp_is_write[1]); else passed++;
        tick();
        total++; if (a.resp_valid !== 2'b00) $display("FAIL read_late got %b want 00", a.resp_valid); else passed++;
        total++; if (a.resp_data[1] !== 8'hA5) $display("FAIL read_hold got %h want a5", a.resp_data[1]); else passed++;
    endtask

    task automatic test_write;
        a.grant_valid = 2'b10; a.grant_consumer[1] = 1'b0; a.grant_wr = 2'b10; a.plm_outputs[1] = 8'hFF;
        #1;
        total++; if (a.req_ack !== 2'b01) $display("FAIL write_ack got %b want 01", a.req_ack); else passed++;
        tick();
        idle(); a.plm_outputs[1] = 8'h77;
        tick();
        idle();
        total++; if (a.resp_valid !== 2'b01) $display("FAIL write_rv got %b want 01", a.resp_valid); else passed++;
        total++; if (a.resp_is_write[0] !== 1'b1) $display("FAIL write_flag got %b want 1", a.resp_is_write[0]); else passed++;
        total++; if (a.resp_data[0] !== 8'h00) $display("FAIL write_data got %h want 00", a.resp_data[0]); else passed++;
        total++; if (a.error !== 2'b00) $display("FAIL write_err got %b want 00", a.error); else passed++;
        tick();
    endtask

    task automatic test_collision;
        a.grant_valid = 2'b11; a.grant_consumer = '0; a.grant_wr = 2'b00;
        #1;
        total++; if (a.req_ack !== 2'b01) $display("FAIL coll_ack got %b want 01", a.req_ack); else passed++;
        tick();
        idle(); a.plm_outputs[0] = 8'h11; a.plm_outputs[1] = 8'h22;
        tick();
        idle();
        total++; if (a.resp_valid !== 2'b01) $display("FAIL coll_rv got %b want 01", a.resp_valid); else passed++;
        total++; if (a.resp_data[0] !== 8'h11) $display("FAIL coll_data got %h want 11", a.resp_data[0]); else passed++;
        total++; if (a.error !== 2'b01) $display("FAIL coll_err got %b want 01", a.error); else passed++;
        tick(); tick(); tick();
        total++; if (a.error !== 2'b01) $display("FAIL coll_sticky got %b want 01", a.error); else passed++;
    endtask

    task automatic test_reset_midflight;
        a.grant_valid = 2'b01; a.grant_consumer[0] = 1'b1;
        tick();
        idle(); reset = 1'b1; a.plm_outputs[0] = 8'h5A;
        tick();
        reset = 1'b0; idle();
        total++; if (a.resp_valid !== 2'b00) $display("FAIL mid_rv got %b want 00", a.resp_valid); else passed++;
        total++; if (a.grant_count !== '0) $display("FAIL mid_cnt got %h want 0", a.grant_count); else passed++;
        total++; if (a.error !== 2'b00) $display("FAIL mid_err got %b want 00", a.error); else passed++;
        a.grant_valid = 2'b01; a.grant_consumer[0] = 1'b0;
        tick();
        idle(); a.plm_outputs[0] = 8'h3C;
        total++; if (a.resp_valid !== 2'b00) $display("FAIL mid_ghost got %b want 00", a.resp_valid); else passed++;
        tick();
        idle();
        total++; if (a.resp_valid !== 2'b01 || a.resp_data[0] !== 8'h3C) $display("FAIL mid_next got %b/%h want 01/3c", a.resp_valid, a.resp_data[0]); else passed++;
        tick();
    endtask

    task automatic test_streaming;
        int cons[3] = '{0, 1, 0};
        logic [2:0] exp_v;
        for (int i = 0; i < 6; i++) begin
            b.grant_valid = (i < 3) ? 2'b01 : 2'b00;
            b.grant_consumer[0] = (i < 3) ? 2'(cons[i]) : 2'd0;
            b.plm_outputs[0] = (i >= 2 && i <= 4) ? 8'(i - 1) : 8'h00;
            #1;
            if (i < 3) begin
                exp_v = 3'b001 << cons[i];
                total++; if (b.req_ack !== exp_v) $display("FAIL stream_ack%0d got %b want %b", i, b.req_ack, exp_v); else passed++;
            end
            if (i == 2) begin
                total++; if (b.resp_valid !== 3'b000) $display("FAIL stream_early got %b want 000", b.resp_valid); else passed++;
            end
            if (i >= 3) begin
                exp_v = 3'b001 << cons[i-3];
                total++; if (b.resp_valid !== exp_v) $display("FAIL stream_rv%0d got %b want %b", i, b.resp_valid, exp_v); else passed++;
                total++; if (b.resp_data[cons[i-3]] !== 8'(i - 2)) $display("FAIL stream_data%0d got %h want %h", i, b.resp_data[cons[i-3]], 8'(i - 2)); else passed++;
            end
            tick();
        end
        idle();
        total++; if (b.resp_valid !== 3'b000) $display("FAIL stream_end got %b want 000", b.resp_valid); else passed++;
    endtask

    task automatic test_out_of_range;
        b.grant_valid = 2'b01; b.grant_consumer[0] = 2'd3;
        #1;
        total++; if (b.req_ack !== 3'b000) $display("FAIL oor_ack got %b want 000", b.req_ack); else passed++;
        tick();
        idle();
        total++; if (b.error !== 2'b10) $display("FAIL oor_err got %b want 10", b.error); else passed++;
        tick();
        b.plm_outputs[0] = 8'h99;
        tick();
        idle();
        total++; if (b.resp_valid !== 3'b000) $display("FAIL oor_rv got %b want 000", b.resp_valid); else passed++;
    endtask

    task automatic test_counters;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a.grant_valid = 2'b10; a.grant_consumer[1] = 1'b0; a.grant_wr = 2'b10;
        repeat (14) tick();
        total++; if (a.grant_count[1] !== 4'd14) $display("FAIL cnt_14 got %0d want 14", a.grant_count[1]); else passed++;
        repeat (6) tick();
        total++; if (a.grant_count[1] !== 4'd15) $display("FAIL cnt_sat got %0d want 15", a.grant_count[1]); else passed++;
        total++; if (a.grant_count[0] !== 4'd0) $display("FAIL cnt_k0 got %0d want 0", a.grant_count[0]); else passed++;
        a.clear_stats = 1'b1;
        tick();
        idle();
        total++; if (a.grant_count[1] !== 4'd0) $display("FAIL cnt_clear got %0d want 0", a.grant_count[1]); else passed++;
        a.grant_valid = 2'b10; a.grant_wr = 2'b10;
        tick();
        idle();
        total++; if (a.grant_count[1] !== 4'd1) $display("FAIL cnt_after got %0d want 1", a.grant_count[1]); else passed++;
        total++; if (a.error !== 2'b00) $display("FAIL cnt_err got %b want 00", a.error); else passed++;
    endtask

    // directed scenarios in sequence, then the summary
    initial begin
        test_reset();
        test_read();
        test_write();
        test_collision();
        test_reset_midflight();
        test_streaming();
        test_out_of_range();
        test_counters();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rr_response_router.md
# rr_response_router

Downstream companion of the round-robin scheduling kernels. It acknowledges each consumer request in the cycle a kernel grants it, then tracks every grant through the PLM read latency. It routes the returning PLM output word (or a write completion) back to the consumer that issued the request, and keeps per-kernel grant statistics and sticky error flags for the scheduler.

## Interface
- VALUE_WIDTH, 8, data word width of PLM outputs and responses
- NCONSUMERS, 2, number of consumer ports; CW = max(1, $clog2(NCONSUMERS))
- NBANKS, 2, PLM banks
- NPORTS, 1, ports per bank (1 or 2); NKERNELS = NBANKS*NPORTS, must be > 1
- PLM_LATENCY, 1, cycles from grant to valid plm_outputs (legal 1..3)
- CNT_WIDTH, 16, width of each saturating grant counter

Ports:
- clk  input  1  single clock, all state on posedge
- reset  input  1  synchronous, active-high
- grant_valid  input  [NKERNELS]  kernel k issued a PLM access this cycle
- grant_consumer  input  [CW] x NKERNELS  consumer index served by kernel k
- grant_wr  input  [NKERNELS]  granted access is a write
- plm_outputs  input  [VALUE_WIDTH] x NKERNELS  PLM read data, valid PLM_LATENCY cycles after grant
- clear_stats  input  1  one-cycle pulse, zeroes grant counters
- req_ack  output  [NCONSUMERS]  combinational; consumer c was granted this cycle
- resp_valid  output  [NCONSUMERS]  registered response strobe
- resp_data  output  [VALUE_WIDTH] x NCONSUMERS  read data (0 for writes)
- resp_is_write  output  [NCONSUMERS]  response is a write completion
- grant_count  output  [CNT_WIDTH] x NKERNELS  saturating grants per kernel
- error  output  2  sticky: bit0 routing collision, bit1 out-of-range consumer index

## Operation
- req_ack[c] = OR over k of (grant_valid[k] && grant_consumer[k]==c). It is purely combinational, so a consumer advances its request before the next pivot rotation can re-grant it.
- Tracking pipeline: per kernel, a PLM_LATENCY-deep shift line of {valid, consumer, wr}. It is loaded from the grant inputs every cycle; its tail entry aligns with plm_outputs.
- Tail resolution, per consumer c: candidate kernels are those with tail valid and tail consumer==c.
  - Exactly one candidate k: next resp_valid[c]=1, resp_data[c] = wr ? 0 : plm_outputs[k], resp_is_write[c]=wr.
  - More than one: lowest-index k wins, the others are dropped, error[0] set.
  - None: resp_valid[c]=0. resp_data and resp_is_write hold their previous values.
- Grant with grant_consumer >= NCONSUMERS: no ack, no response, error[1] set in the grant cycle's next edge.
- grant_count[k]: +1 per cycle with grant_valid[k], saturates at all-ones. clear_stats wins over a simultaneous increment (result 0).
- error bits clear only on reset.
- Reset: pipeline valids, resp_valid, resp_data, resp_is_write, grant_count and error all go to 0. In-flight grants are discarded; no response from them ever appears.

## Timing
- Grant in cycle t: req_ack in cycle t. plm_outputs sampled at the end of cycle t+PLM_LATENCY. resp_valid is high for exactly cycle t+PLM_LATENCY+1.
- Full throughput: each kernel accepts one grant every cycle with no bubbles. Responses to one consumer emerge in grant order.
- Reset asserted in cycle r: all outputs except req_ack read 0 from cycle r+1. The first post-reset grant responds with normal latency.
- req_ack follows the inputs even during reset.

## Test plan
- Read: cycle 5, grant_valid[0]=1, consumer 1, wr 0; plm_outputs[0]=8'hA5 in cycle 6 -> req_ack=2'b10 in cycle 5; resp_valid[1]=1 with data 8'hA5 in cycle 7 only; resp_valid[0]=0 throughout.
- Write: kernel 1 grants consumer 0 with wr=1 -> resp_valid[0]=1, resp_is_write[0]=1, resp_data[0]=8'h00 two cycles later; error=0.
- Collision: kernels 0 and 1 grant consumer 0 in the same cycle; plm_outputs 8'h11/8'h22 -> single response 8'h11; error[0]=1 and it stays 1 until reset.
- Streaming, PLM_LATENCY=2: kernel 0 grants consumers 0,1,0 on consecutive cycles; data 1,2,3 -> responses on consecutive cycles t+3..t+5 to consumers 0,1,0 with data 1,2,3; no gaps.
- Reset mid-flight: grant at t, reset in cycle t+1 -> no resp_valid in t+2; grant_count and error read 0; the next grant responds normally.
- Counters, CNT_WIDTH=4: 20 grants on kernel 1 -> grant_count[1]=15. clear_stats coincident with a grant -> 0 next cycle; the following grant gives 1.
